mux42_rr_sched: RTL and testbench
=================================

Name: mux42_rr_sched

Overview:
- Round-robin scheduler for the 4-to-2 byte mux in the PCIe physical-layer byte-striping path.
- Each cycle it arbitrates four requesting byte sources onto two output lanes and returns a per-source ready.
- It drives registered lane data (out0/out1) with lane-valid flags (validout).
- Supports downstream backpressure, a per-source enable mask and a forwarded-byte counter.

Parameters:
DATA_W, 8, width of each input/output byte lane
CNT_W, 16, width of forwarded-byte counter

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
in0  input  DATA_W  source 0 data
in1  input  DATA_W  source 1 data
in2  input  DATA_W  source 2 data
in3  input  DATA_W  source 3 data
valid  input  4  per-source request; bit i qualifies in_i
lane_mask  input  4  per-source enable; masked sources are never granted
out_stall  input  1  downstream backpressure; 1 = freeze outputs, no grants
ready  output  4  per-source grant, combinational; transfer occurs when valid[i]&ready[i] at clk edge
out0  output  DATA_W  lane 0 data, registered
out1  output  DATA_W  lane 1 data, registered
validout  output  2  lane valid flags, registered; bit0 = lane0, bit1 = lane1
byte_cnt  output  CNT_W  total bytes forwarded, registered

Behaviour:
- Reset (reset=0, async, no clk needed): out0=0, out1=0, validout=2'b00, byte_cnt=0, rr_ptr=0. Outputs hold these values while reset=0; ready=0 while reset=0.
- Internal state: rr_ptr[1:0], the first source checked in the next scan.
- Eligibility (combinational): elig = valid & lane_mask & {4{~out_stall}}.
- Scan order: rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3, all mod 4.
- g0 = first eligible source in scan order. g1 = next eligible source after g0.
- ready = onehot(g0) | onehot(g1). Unused grants contribute 0. At most 2 bits of ready are set.
- Lane ordering: lane0 always takes g0. Lane1 is filled only when g0 exists, so validout=2'b10 never occurs.
- Clock edge, out_stall=0, reset=1:
  - out0 <= in[g0] if g0 exists, else 0. validout[0] <= (g0 exists).
  - out1 <= in[g1] if g1 exists, else 0. validout[1] <= (g1 exists).
  - rr_ptr <= (last granted index + 1) mod 4, where last granted is g1 if present, else g0. rr_ptr unchanged if no grant.
  - byte_cnt <= byte_cnt + (number of grants: 0/1/2), wraps modulo 2^CNT_W.
- Clock edge, out_stall=1: out0, out1, validout, rr_ptr and byte_cnt hold; ready=0 combinationally.
- Latency: 1 cycle from accepted handshake to data on out0/out1.
- Sources must hold data stable while valid=1 and ready=0. Valid deasserting without a grant is legal; nothing is consumed.
- lane_mask changes take effect in the same cycle's grant computation.
- Reset mid-stream: asynchronously clears all state. In-flight output data is discarded; the first scan after release starts at source 0.
- Wrap: rr_ptr 3 -> 0. Scan from rr_ptr=3 over all-eligible grants 3 then 0, giving rr_ptr=1.
- No grant is ever issued to a source with lane_mask[i]=0, even if it is the only requester.

Test Plan:
1. Assert reset=0 mid-cycle with validout=11 -> out0=out1=0, validout=00, byte_cnt=0, ready=0, all immediately without a clk edge.
2. valid=1111, lane_mask=1111, in0..in3=A0,A1,A2,A3, rr_ptr=0:
   - edge1 -> out0=A0, out1=A1, validout=11, rr_ptr=2.
   - edge2 -> out0=A2, out1=A3, rr_ptr=0.
   - byte_cnt=4.
3. Only valid=0100 (in2=5C) -> ready=0100; next edge out0=5C, out1=00, validout=01, rr_ptr=3, byte_cnt +1.
4. rr_ptr=2, valid=1001, in3=33, in0=00F -> ready=1001; next edge out0=in3, out1=in0, validout=11, rr_ptr=1.
5. Streaming, then out_stall=1 for 3 cycles -> ready=0000; out0/out1/validout/byte_cnt/rr_ptr unchanged. Release -> grants resume from held rr_ptr.
6. valid=1111, lane_mask=0101 -> grants only sources 0 and 2, every cycle (ready=0101). Then byte_cnt preloaded near FFFF via 32768 two-byte cycles -> counter wraps to 0000.

Source files
------------

// File: rtl/mux42_rr_sched.sv
// Round-robin 4-to-2 byte scheduler: up to two grants per cycle, registered lane data one cycle after handshake.
// out_stall freezes all registered state and withholds every grant (ready=0).
module mux42_rr_sched #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [3:0]        valid,
  input  logic [3:0]        lane_mask,
  input  logic              out_stall,
  output logic [3:0]        ready,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [1:0]        validout,
  output logic [CNT_W-1:0]  byte_cnt
);

  logic [1:0]        rr_ptr;
  logic [3:0]        elig;
  logic              g0_vld;
  logic              g1_vld;
  logic [1:0]        g0;
  logic [1:0]        g1;
  logic [1:0]        idx;
  logic [1:0]        next_ptr;
  logic [DATA_W-1:0] src [4];

  assign src[0] = in0;
  assign src[1] = in1;
  assign src[2] = in2;
  assign src[3] = in3;

  // Gating with reset keeps ready low while the block is held in reset.
  assign elig = valid & lane_mask & {4{~out_stall & reset}};

  always_comb begin
    g0_vld = 1'b0;
    g1_vld = 1'b0;
    g0     = 2'd0;
    g1     = 2'd0;
    idx    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (elig[idx]) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0     = idx;
        end else if (!g1_vld) begin
          g1_vld = 1'b1;
          g1     = idx;
        end
      end
    end
  end

  assign ready    = ({3'b000, g0_vld} << g0) | ({3'b000, g1_vld} << g1);
  assign next_ptr = (g1_vld ? g1 : g0) + 2'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out0     <= '0;
      out1     <= '0;
      validout <= 2'b00;
      byte_cnt <= '0;
      rr_ptr   <= 2'd0;
    end else if (!out_stall) begin
      out0     <= g0_vld ? src[g0] : '0;
      out1     <= g1_vld ? src[g1] : '0;
      validout <= {g1_vld, g0_vld};
      byte_cnt <= byte_cnt + CNT_W'(g0_vld) + CNT_W'(g1_vld);
      if (g0_vld) begin
        rr_ptr <= next_ptr;
      end
    end
  end

endmodule

// File: tb/tb_mux42_rr_sched.sv
// Bench for mux42_rr_sched: directed literal cases plus randomized traffic against a queue-based scan model.
module tb_mux42_rr_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_d [4];
  logic [3:0]  valid;
  logic [3:0]  lane_mask;
  logic        out_stall;
  logic [3:0]  ready;
  logic [7:0]  out0;
  logic [7:0]  out1;
  logic [1:0]  validout;
  logic [15:0] byte_cnt;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // model state
  logic [7:0]  m_out0;
  logic [7:0]  m_out1;
  logic [1:0]  m_vo;
  logic [15:0] m_cnt;
  int          m_ptr;

  mux42_rr_sched #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in0(in_d[0]), .in1(in_d[1]), .in2(in_d[2]), .in3(in_d[3]),
    .valid(valid), .lane_mask(lane_mask), .out_stall(out_stall),
    .ready(ready), .out0(out0), .out1(out1), .validout(validout),
    .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Eligible sources listed in scan order from ptr; the first two are the grants.
  function automatic void model_grants(input int ptr, output int g0, output int g1);
    int q[$];
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (ptr + k) % 4;
      if (valid[i] && lane_mask[i] && !out_stall && reset) q.push_back(i);
    end
    g0 = (q.size() > 0) ? q[0] : -1;
    g1 = (q.size() > 1) ? q[1] : -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int g0, g1;
    logic [3:0] r;
    model_grants(m_ptr, g0, g1);
    r = 4'b0000;
    if (g0 >= 0) r[g0] = 1'b1;
    if (g1 >= 0) r[g1] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    int g0, g1;
    if (!reset) begin
      m_out0 = '0; m_out1 = '0; m_vo = 2'b00; m_cnt = '0; m_ptr = 0;
    end else if (!out_stall) begin
      model_grants(m_ptr, g0, g1);
      m_out0 = (g0 >= 0) ? in_d[g0] : 8'h00;
      m_out1 = (g1 >= 0) ? in_d[g1] : 8'h00;
      m_vo   = {g1 >= 0, g0 >= 0};
      if (g0 >= 0) m_ptr = (((g1 >= 0) ? g1 : g0) + 1) % 4;
      m_cnt = m_cnt + 16'((g0 >= 0) ? 1 : 0) + 16'((g1 >= 0) ? 1 : 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ready",    32'(ready),    32'(model_ready()));
      chk("m_out0",     32'(out0),     32'(m_out0));
      chk("m_out1",     32'(out1),     32'(m_out1));
      chk("m_validout", 32'(validout), 32'(m_vo));
      chk("m_byte_cnt", 32'(byte_cnt), 32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; valid = 4'b0000; lane_mask = 4'b1111; out_stall = 1'b0;
    for (int i = 0; i < 4; i++) in_d[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_validout", 32'(validout), 'h0);
    chk("rst_byte_cnt", 32'(byte_cnt), 'h0);

    // async reset while both lanes are valid
    reset = 1'b1;
    in_d[0] = 8'hA0; in_d[1] = 8'hA1; in_d[2] = 8'hA2; in_d[3] = 8'hA3;
    valid = 4'b1111;
    tick();
    chk("pre_rst_validout", 32'(validout), 'h3);
    #2 reset = 1'b0;
    #1;
    chk("arst_out0", 32'(out0), 'h0);
    chk("arst_out1", 32'(out1), 'h0);
    chk("arst_validout", 32'(validout), 'h0);
    chk("arst_byte_cnt", 32'(byte_cnt), 'h0);
    chk("arst_ready", 32'(ready), 'h0);

    // all sources valid from rr_ptr=0
    @(posedge clk); #1 reset = 1'b1;
    #1 chk("t2_ready0", 32'(ready), 'b0011);
    tick();
    chk("t2_out0_a", 32'(out0), 'hA0);
    chk("t2_out1_a", 32'(out1), 'hA1);
    chk("t2_vo_a", 32'(validout), 'h3);
    chk("t2_ready1", 32'(ready), 'b1100);
    tick();
    chk("t2_out0_b", 32'(out0), 'hA2);
    chk("t2_out1_b", 32'(out1), 'hA3);
    chk("t2_cnt", 32'(byte_cnt), 4);

    // single requester
    valid = 4'b0100; in_d[2] = 8'h5C;
    #1 chk("t3_ready", 32'(ready), 'b0100);
    tick();
    chk("t3_out0", 32'(out0), 'h5C);
    chk("t3_out1", 32'(out1), 'h00);
    chk("t3_vo", 32'(validout), 'h1);
    chk("t3_cnt", 32'(byte_cnt), 5);

    // move rr_ptr to 2, then wrap 3 -> 0
    valid = 4'b0010;
    #1 chk("t4_pre_ready", 32'(ready), 'b0010);
    tick();
    valid = 4'b1001; in_d[3] = 8'h33; in_d[0] = 8'h0F;
    #1 chk("t4_ready", 32'(ready), 'b1001);
    tick();
    chk("t4_out0", 32'(out0), 'h33);
    chk("t4_out1", 32'(out1), 'h0F);
    chk("t4_vo", 32'(validout), 'h3);
    chk("t4_cnt", 32'(byte_cnt), 8);

    // stall holds everything
    valid = 4'b1111; out_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 chk("t5_ready", 32'(ready), 'h0);
      tick();
      chk("t5_out0", 32'(out0), 'h33);
      chk("t5_out1", 32'(out1), 'h0F);
      chk("t5_vo", 32'(validout), 'h3);
      chk("t5_cnt", 32'(byte_cnt), 8);
    end
    out_stall = 1'b0;
    #1 chk("t5_resume_ready", 32'(ready), 'b0110);
    tick();
    chk("t5_resume_out0", 32'(out0), 'hA1);
    chk("t5_resume_out1", 32'(out1), 'h5C);
    chk("t5_resume_cnt", 32'(byte_cnt), 10);

    // mask limits grants to sources 0 and 2
    lane_mask = 4'b0101;
    for (int c = 0; c < 3; c++) begin
      #1 chk("t6_ready", 32'(ready), 'b0101);
      tick();
      chk("t6_out0", 32'(out0), 'h0F);
      chk("t6_out1", 32'(out1), 'h5C);
    end
    valid = 4'b0010;
    #1 chk("t6_masked_only", 32'(ready), 'h0);
    tick();
    chk("t6_masked_vo", 32'(validout), 'h0);

    // randomized traffic, checked by the negedge compare process
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) in_d[i] = 8'($urandom);
      valid     = 4'($urandom);
      lane_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
      out_stall = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b0;
        tick();
        reset = 1'b1;
      end else begin
        tick();
      end
    end

    // counter wrap: 32768 two-byte cycles from zero
    out_stall = 1'b0;
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    valid = 4'b1111; lane_mask = 4'b1111;
    repeat (32767) tick();
    chk("wrap_pre", 32'(byte_cnt), 'hFFFE);
    tick();
    chk("wrap_zero", 32'(byte_cnt), 'h0000);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
